// File: rtl/axil_pkg.sv
// axil_pkg: state encoding, AXI response codes and a width helper shared by the
// AXI-Lite arbiter and its round-robin picker.
package axil_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/axil_rr_picker.sv
// axil_rr_picker: combinational round-robin selector; picks the first requester
// at or above the pointer, wrapping past N_MST-1 back to 0.
module axil_rr_picker import axil_pkg::*; #(
    parameter int N_MST = 2
) (
    input  logic [N_MST-1:0]        req,
    input  logic [clog2(N_MST)-1:0] pointer,
    output logic [clog2(N_MST)-1:0] winner,
    output logic                    any_req
);
    localparam int IDX_W = clog2(N_MST);
    int w_idx;
    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        winner = '0;
        w_idx = 0;
        for (int k = N_MST - 1; k >= 0; k--) begin
            w_idx = int'(pointer) + k;
            if (w_idx >= N_MST) w_idx = w_idx - N_MST;
            if (req[IDX_W'(w_idx)]) winner = IDX_W'(w_idx);
        end
    end
    assign any_req = |req;
endmodule

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: N-master to 1-slave AXI-Lite arbiter, round-robin grant held for one transaction.
// Define AXIL_ARB_PERF_EN to add per-master completion counters (perf_cnt) and a wait counter (perf_wait).
module axil_rr_arbiter import axil_pkg::*; #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MST*ADDR_W-1:0]      m_araddr,
    input  logic [N_MST*ADDR_W-1:0]      m_awaddr,
    input  logic [N_MST-1:0]             m_arvalid,
    input  logic [N_MST-1:0]             m_awvalid,
    input  logic [N_MST-1:0]             m_wvalid,
    input  logic [N_MST-1:0]             m_rready,
    input  logic [N_MST-1:0]             m_bready,
    input  logic [N_MST*DATA_W-1:0]      m_wdata,
    input  logic [N_MST*DATA_W/8-1:0]    m_wstrb,
    output logic [N_MST-1:0]             m_arready,
    output logic [N_MST-1:0]             m_awready,
    output logic [N_MST-1:0]             m_wready,
    output logic [N_MST-1:0]             m_rvalid,
    output logic [N_MST-1:0]             m_bvalid,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [1:0]                   m_rresp,
    output logic [1:0]                   m_bresp,
    output logic [ADDR_W-1:0]            s_araddr,
    output logic [ADDR_W-1:0]            s_awaddr,
    output logic                         s_arvalid,
    output logic                         s_awvalid,
    output logic                         s_wvalid,
    output logic                         s_rready,
    output logic                         s_bready,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_arready,
    input  logic                         s_awready,
    input  logic                         s_wready,
    input  logic                         s_rvalid,
    input  logic                         s_bvalid,
    input  logic [DATA_W-1:0]            s_rdata,
    input  logic [1:0]                   s_rresp,
    input  logic [1:0]                   s_bresp,
    output logic [clog2(N_MST)-1:0]      grant_id,
    output logic                         busy
`ifdef AXIL_ARB_PERF_EN
    ,
    output logic [N_MST*32-1:0]          perf_cnt,
    output logic [31:0]                  perf_wait
`endif
);
    localparam int IDX_W  = clog2(N_MST);
    localparam int STRB_W = DATA_W / 8;
    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic               r_aw_done;
    logic               r_w_done;
    logic [N_MST-1:0]   w_req;
    logic [N_MST-1:0]   w_gsel;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_next;
    logic               w_any;
    logic               w_rd_addr, w_rd_data, w_wr_addr, w_wr_resp;
    logic               w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
    logic               w_aw_fin, w_w_fin;

    assign w_req = m_arvalid | m_awvalid;

    axil_rr_picker #(.N_MST(N_MST)) u_picker (
        .req     (w_req),
        .pointer (r_ptr),
        .winner  (w_win),
        .any_req (w_any)
    );

    assign w_rd_addr = r_state == RD_ADDR;
    assign w_rd_data = r_state == RD_DATA;
    assign w_wr_addr = r_state == WR_ADDR;
    assign w_wr_resp = r_state == WR_RESP;
    assign w_gsel    = N_MST'(1) << r_grant;
    assign w_next    = (r_grant == IDX_W'(N_MST - 1)) ? '0 : r_grant + IDX_W'(1);

    assign s_araddr  = m_araddr[r_grant*ADDR_W +: ADDR_W];
    assign s_awaddr  = m_awaddr[r_grant*ADDR_W +: ADDR_W];
    assign s_wdata   = m_wdata[r_grant*DATA_W +: DATA_W];
    assign s_wstrb   = m_wstrb[r_grant*STRB_W +: STRB_W];
    assign s_arvalid = w_rd_addr & m_arvalid[r_grant];
    // A write channel that has already handshaken stops driving its valid/ready.
    assign s_awvalid = w_wr_addr & ~r_aw_done & m_awvalid[r_grant];
    assign s_wvalid  = w_wr_addr & ~r_w_done & m_wvalid[r_grant];
    assign s_rready  = w_rd_data & m_rready[r_grant];
    assign s_bready  = w_wr_resp & m_bready[r_grant];

    assign m_arready = {N_MST{w_rd_addr & s_arready}} & w_gsel;
    assign m_awready = {N_MST{w_wr_addr & ~r_aw_done & s_awready}} & w_gsel;
    assign m_wready  = {N_MST{w_wr_addr & ~r_w_done & s_wready}} & w_gsel;
    assign m_rvalid  = {N_MST{w_rd_data & s_rvalid}} & w_gsel;
    assign m_bvalid  = {N_MST{w_wr_resp & s_bvalid}} & w_gsel;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_bresp   = s_bresp;
    assign grant_id  = r_grant;
    assign busy      = r_state != IDLE;

    assign w_ar_hs  = s_arvalid & s_arready;
    assign w_aw_hs  = s_awvalid & s_awready;
    assign w_w_hs   = s_wvalid & s_wready;
    assign w_r_hs   = s_rready & s_rvalid;
    assign w_b_hs   = s_bready & s_bvalid;
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant <= w_win;
                    r_state <= m_awvalid[w_win] ? WR_ADDR : RD_ADDR;
                end
                RD_ADDR: if (w_ar_hs) r_state <= RD_DATA;
                RD_DATA: if (w_r_hs) begin
                    r_state <= IDLE;
                    r_ptr   <= w_next;
                end
                WR_ADDR: if (w_aw_fin & w_w_fin) begin
                    r_state   <= WR_RESP;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_aw_done <= w_aw_fin;
                    r_w_done  <= w_w_fin;
                end
                WR_RESP: if (w_b_hs) begin
                    r_state <= IDLE;
                    r_ptr   <= w_next;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef AXIL_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt  <= '0;
            perf_wait <= '0;
        end else begin
            if (w_r_hs | w_b_hs) perf_cnt[r_grant*32 +: 32] <= perf_cnt[r_grant*32 +: 32] + 32'd1;
            if (w_any & ((r_state == IDLE) | (|(w_req & ~w_gsel)))) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: directed scoreboard bench for axil_rr_arbiter with three masters
// and a behavioural slave driven from the same stepping task.
module tb_axil_rr_arbiter;
    import axil_pkg::*;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N*32-1:0] m_araddr, m_awaddr, m_wdata;
    logic [N*4-1:0]  m_wstrb;
    logic [N-1:0]    m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
    logic [N-1:0]    m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
    logic [31:0]     m_rdata, s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [1:0]      m_rresp, m_bresp, s_rresp, s_bresp;
    logic [3:0]      s_wstrb;
    logic            s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
    logic            s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef AXIL_ARB_PERF_EN
    logic [N*32-1:0] perf_cnt;
    logic [31:0]     perf_wait;
`endif

    axil_rr_arbiter #(.N_MST(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_awaddr(m_awaddr),
        .m_arvalid(m_arvalid), .m_awvalid(m_awvalid), .m_wvalid(m_wvalid),
        .m_rready(m_rready), .m_bready(m_bready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arready(m_arready), .m_awready(m_awready), .m_wready(m_wready),
        .m_rvalid(m_rvalid), .m_bvalid(m_bvalid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_bresp(m_bresp),
        .s_araddr(s_araddr), .s_awaddr(s_awaddr),
        .s_arvalid(s_arvalid), .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
        .s_rready(s_rready), .s_bready(s_bready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_arready(s_arready), .s_awready(s_awready), .s_wready(s_wready),
        .s_rvalid(s_rvalid), .s_bvalid(s_bvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp),
        .grant_id(grant_id), .busy(busy)
`ifdef AXIL_ARB_PERF_EN
        , .perf_cnt(perf_cnt), .perf_wait(perf_wait)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    int          exp_g[$];
    logic [67:0] exp_w[$];
    logic [31:0] rd_q[N][$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] sl_raddr, sl_awaddr, sl_wdata;
    logic [3:0]  sl_wstrb;
    logic        sl_aw_got, sl_w_got, rd_out, wr_out, prev_busy;
    int          sl_rcnt;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'h8000_0413;
    endfunction

    function automatic logic [1:0] rd_resp(input logic [31:0] a);
        return a[2] ? SLVERR : OKAY;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_rd(input int m, input logic [31:0] a);
        exp_q.push_back('{1'b0, m, rd_val(a), rd_resp(a)});
        exp_g.push_back(m);
    endtask

    task automatic issue_rd(input int m, input logic [31:0] a);
        rd_q[m].push_back(a);
        expect_rd(m, a);
    endtask

    task automatic expect_wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{1'b1, m, 32'h0, OKAY});
        exp_g.push_back(m);
        exp_w.push_back({a, d, s});
    endtask

    // Entered at a falling edge: sample what will handshake on the next rising edge, then
    // advance to the following falling edge and update master and slave drives.
    task automatic tick();
        logic [N-1:0] ar_hs, aw_hs, w_hs;
        logic s_ar, s_aw, s_w, s_r, s_b;
        logic [67:0] ew;
        exp_t e;
        #1;
        ar_hs = m_arvalid & m_arready;
        aw_hs = m_awvalid & m_awready;
        w_hs  = m_wvalid & m_wready;
        s_ar = s_arvalid & s_arready;
        s_aw = s_awvalid & s_awready;
        s_w  = s_wvalid & s_wready;
        s_r  = s_rvalid & s_rready;
        s_b  = s_bvalid & s_bready;
        chk("only_granted", 64'((m_arready | m_awready | m_wready | m_rvalid | m_bvalid) & ~(N'(1) << grant_id)), 0);
        if (s_arvalid | s_awvalid | s_wvalid) chk("single_outstanding", 64'(rd_out | wr_out), 0);
        if (busy && !prev_busy) begin
            chk("grant_expected", 64'(exp_g.size() > 0), 1);
            if (exp_g.size() > 0) chk("grant_id", 64'(grant_id), 64'(exp_g.pop_front()));
        end
        prev_busy = busy;
        for (int m = 0; m < N; m++) begin
            if ((m_rvalid[m] & m_rready[m]) | (m_bvalid[m] & m_bready[m])) begin
                chk("resp_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("resp_master", 64'(m), 64'(e.m));
                    chk("resp_kind", 64'(m_bvalid[m]), 64'(e.wr));
                    chk("resp_code", 64'(e.wr ? m_bresp : m_rresp), 64'(e.resp));
                    if (!e.wr) chk("rdata", 64'(m_rdata), 64'(e.data));
                end
            end
        end
        @(negedge clk);
        m_arvalid &= ~ar_hs;
        m_awvalid &= ~aw_hs;
        m_wvalid  &= ~w_hs;
        for (int m = 0; m < N; m++) begin
            if (!m_arvalid[m] && rd_q[m].size() > 0) begin
                m_araddr[m*32 +: 32] = rd_q[m].pop_front();
                m_arvalid[m] = 1'b1;
            end
        end
        if (s_r) begin
            s_rvalid = 1'b0;
            rd_out = 1'b0;
        end
        if (s_b) begin
            s_bvalid = 1'b0;
            wr_out = 1'b0;
        end
        if (s_ar) begin
            sl_raddr = s_araddr;
            sl_rcnt = 3;
            rd_out = 1'b1;
        end else if (sl_rcnt > 0) begin
            sl_rcnt--;
            if (sl_rcnt == 0) begin
                s_rvalid = 1'b1;
                s_rdata = rd_val(sl_raddr);
                s_rresp = rd_resp(sl_raddr);
            end
        end
        if (s_aw) begin
            sl_awaddr = s_awaddr;
            sl_aw_got = 1'b1;
        end
        if (s_w) begin
            sl_wdata = s_wdata;
            sl_wstrb = s_wstrb;
            sl_w_got = 1'b1;
        end
        if (sl_aw_got && sl_w_got) begin
            chk("slave_write_expected", 64'(exp_w.size() > 0), 1);
            if (exp_w.size() > 0) begin
                ew = exp_w.pop_front();
                chk("wr_addr", 64'(sl_awaddr), 64'(ew[67:36]));
                chk("wr_data_strb", 64'({sl_wdata, sl_wstrb}), 64'(ew[35:0]));
            end
            sl_aw_got = 1'b0;
            sl_w_got = 1'b0;
            s_bvalid = 1'b1;
            s_bresp = OKAY;
            wr_out = 1'b1;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() > 0 || busy || (|m_arvalid) || (|m_awvalid)) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_in_budget", 64'(k < budget), 1);
    endtask

    task automatic clear_tb_state();
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        s_rvalid = 1'b0; s_bvalid = 1'b0;
        sl_rcnt = 0; sl_aw_got = 1'b0; sl_w_got = 1'b0;
        rd_out = 1'b0; wr_out = 1'b0; prev_busy = 1'b0;
        exp_q.delete(); exp_g.delete(); exp_w.delete();
        for (int m = 0; m < N; m++) rd_q[m].delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 64'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid,
                      s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, busy, grant_id}), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        m_rready = '1; m_bready = '1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        s_rdata = '0; s_rresp = OKAY; s_bresp = OKAY;
        sl_raddr = '0; sl_awaddr = '0; sl_wdata = '0; sl_wstrb = '0;
        clear_tb_state();
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        chk("reset_mux_known", 64'($isunknown({s_araddr, s_awaddr, s_wdata, s_wstrb})), 0);
        // Masters 0 and 1 both request reads while reset is released.
        m_araddr[0 +: 32] = 32'h8000_0010;
        m_araddr[32 +: 32] = 32'h8000_0024;
        m_arvalid = 3'b011;
        expect_rd(0, 32'h8000_0010);
        expect_rd(1, 32'h8000_0024);
        @(negedge clk);
        rst = 1'b1;
        drain(100);
        // Single read from master 0 with the documented data value.
        rd_q[0].push_back(32'h8000_0000);
        exp_q.push_back('{1'b0, 0, 32'h0000_0413, OKAY});
        exp_g.push_back(0);
        drain(100);
        chk("busy_after_read", 64'(busy), 0);
        chk("m1_rvalid_idle", 64'(m_rvalid[1]), 0);
        // Master 1: W two cycles ahead of AW, and AW held off at the slave so W lands first.
        s_awready = 1'b0;
        m_wdata[32 +: 32] = 32'hDEAD_BEEF;
        m_wstrb[4 +: 4] = 4'b0011;
        m_wvalid[1] = 1'b1;
        expect_wr(1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
        tick();
        tick();
        m_awaddr[32 +: 32] = 32'h8000_0100;
        m_awvalid[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("w_accepted_first", 64'(m_wvalid[1]), 0);
        chk("aw_still_pending", 64'(m_awvalid[1]), 1);
        s_awready = 1'b1;
        drain(100);
        // Move the pointer back to 0 with a lone master-2 read.
        issue_rd(2, 32'h8000_0200);
        drain(100);
        // All three masters request continuously for nine reads.
        for (int t = 0; t < 3; t++)
            for (int m = 0; m < N; m++) issue_rd(m, 32'h8000_1000 + 32'(16 * (3 * t + m)) + 32'(4 * m));
        drain(300);
        // Master 0 asserts read and write together; the write must win.
        m_araddr[0 +: 32] = 32'h8000_2000;
        m_awaddr[0 +: 32] = 32'h8000_2008;
        m_wdata[0 +: 32] = 32'h1234_5678;
        m_wstrb[0 +: 4] = 4'hF;
        m_arvalid[0] = 1'b1;
        m_awvalid[0] = 1'b1;
        m_wvalid[0] = 1'b1;
        expect_wr(0, 32'h8000_2008, 32'h1234_5678, 4'hF);
        expect_rd(0, 32'h8000_2000);
        drain(100);
        // Reset in the middle of a master-2 read data phase.
        issue_rd(1, 32'h8000_3000);
        drain(100);
        rd_q[2].push_back(32'h8000_3010);
        exp_g.push_back(2);
        k = 0;
        while (!s_rready && k < 20) begin
            tick();
            k++;
        end
        chk("reached_rd_data", 64'(s_rready), 1);
        #2 rst = 1'b0;
        #1;
        check_all_zero("mid_txn_reset_outputs");
        clear_tb_state();
        @(negedge clk);
        rst = 1'b1;
        issue_rd(1, 32'h8000_4000);
        issue_rd(2, 32'h8000_4014);
        drain(100);
        chk("busy_final", 64'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
